// File: rtl/rename_regfile_mp_if.sv
// Bundled issue/commit/read bus for rename_regfile_mp.
// The master side is issue + ROB commit; the slave side is the register file.
interface rename_regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCM   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*ROB_W-1:0] rd_tag;
  logic                 ren_valid;
  logic [AW-1:0]        ren_rd;
  logic [ROB_W-1:0]     ren_tag;
  logic [NCM-1:0]       cm_valid;
  logic [NCM*AW-1:0]    cm_rd;
  logic [NCM*ROB_W-1:0] cm_tag;
  logic [NCM*XLEN-1:0]  cm_data;
  logic [AW:0]          busy_cnt;

  modport master (
    output rd_addr, ren_valid, ren_rd, ren_tag, cm_valid, cm_rd, cm_tag, cm_data,
    input  rd_data, rd_busy, rd_tag, busy_cnt
  );
  modport slave (
    input  rd_addr, ren_valid, ren_rd, ren_tag, cm_valid, cm_rd, cm_tag, cm_data,
    output rd_data, rd_busy, rd_tag, busy_cnt
  );
endinterface

// File: rtl/rename_regfile_mp.sv
// Architectural register file with ROB rename tags, N read / up to 2 commit ports.
// Optional same-cycle commit-to-read bypass under `RF_COMMIT_BYPASS_EN.
module rename_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCM   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  rename_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [XLEN-1:0]  data_d [NREGS];
  logic [ROB_W-1:0] tag_q  [NREGS];
  logic [ROB_W-1:0] tag_d  [NREGS];
  logic [NREGS-1:0] busy_q, busy_d, clr;
  logic [AW:0]      cnt_q, cnt_d, dec;
  logic             ren_hit, ren_new;

  logic [NRD-1:0][AW-1:0]    rd_addr_a;
  logic [NRD-1:0][XLEN-1:0]  rd_data_a;
  logic [NRD-1:0][ROB_W-1:0] rd_tag_a;
  logic [NRD-1:0]            rd_busy_a;
  logic [NCM-1:0][AW-1:0]    cm_rd_a;
  logic [NCM-1:0][ROB_W-1:0] cm_tag_a;
  logic [NCM-1:0][XLEN-1:0]  cm_data_a;

  assign rd_addr_a = bus.rd_addr;
  assign cm_rd_a   = bus.cm_rd;
  assign cm_tag_a  = bus.cm_tag;
  assign cm_data_a = bus.cm_data;

  assign ren_hit = bus.ren_valid && (bus.ren_rd != '0);
  assign ren_new = ren_hit && !busy_q[bus.ren_rd];

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    clr    = '0;
    dec    = '0;
    if (rdy) begin
      // Ascending port order lets the younger commit (port 1) win the data write.
      for (int k = 0; k < NCM; k++) begin
        if (bus.cm_valid[k] && cm_rd_a[k] != '0) begin
          data_d[cm_rd_a[k]] = cm_data_a[k];
          if (tag_q[cm_rd_a[k]] == cm_tag_a[k] && !(ren_hit && bus.ren_rd == cm_rd_a[k]))
            clr[cm_rd_a[k]] = 1'b1;
        end
      end
      if (flush) begin
        busy_d = '0;
        cnt_d  = '0;
      end else begin
        for (int r = 0; r < NREGS; r++) begin
          if (clr[r] && busy_q[r]) begin
            busy_d[r] = 1'b0;
            dec       = dec + (AW+1)'(1);
          end
        end
        if (ren_hit) begin
          busy_d[bus.ren_rd] = 1'b1;
          tag_d[bus.ren_rd]  = bus.ren_tag;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, ren_new} - dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data_a[i] = data_q[rd_addr_a[i]];
      rd_busy_a[i] = busy_q[rd_addr_a[i]];
      rd_tag_a[i]  = tag_q[rd_addr_a[i]];
`ifdef RF_COMMIT_BYPASS_EN
      // Bypass only when the commit will actually land this edge.
      if (rdy && rd_addr_a[i] != '0) begin
        for (int k = 0; k < NCM; k++) begin
          if (bus.cm_valid[k] && cm_rd_a[k] == rd_addr_a[i]) begin
            rd_data_a[i] = cm_data_a[k];
            if (cm_tag_a[k] == tag_q[rd_addr_a[i]] && !(ren_hit && bus.ren_rd == rd_addr_a[i]))
              rd_busy_a[i] = 1'b0;
          end
        end
      end
`endif
      if (rd_addr_a[i] == '0) begin
        rd_data_a[i] = '0;
        rd_busy_a[i] = 1'b0;
        rd_tag_a[i]  = '0;
      end
    end
  end

  assign bus.rd_data  = rd_data_a;
  assign bus.rd_busy  = rd_busy_a;
  assign bus.rd_tag   = rd_tag_a;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file with rename tags for the Tomasulo/ROB core.
- Sits between issue (operand lookup, destination rename) and ROB commit (writeback, tag release).
- Adds over the previous generation:
  - N read ports and up to 2 commit ports.
  - Tag-qualified busy release: a stale commit cannot clear a newer rename.
  - Registered busy-register counter for issue throttling.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural register count (power of 2); AW = $clog2(NREGS).
- ROB_W, 4, ROB tag width.
- NRD, 2, number of read ports.
- NCM, 1, number of commit ports (1 or 2); port 1 is younger than port 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  misbranch flush.
- rd_addr  in  NRD*AW  read-port register indices, port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  operand value per port.
- rd_busy  out  NRD  operand pending per port.
- rd_tag  out  NRD*ROB_W  producing ROB tag per port.
- ren_valid  in  1  rename request from issue.
- ren_rd  in  AW  destination register.
- ren_tag  in  ROB_W  ROB tag allocated to destination.
- cm_valid  in  NCM  commit valid per port.
- cm_rd  in  NCM*AW  commit destination.
- cm_tag  in  NCM*ROB_W  ROB tag of the committing entry.
- cm_data  in  NCM*XLEN  commit value.
- busy_cnt  out  AW+1  number of busy registers (registered).

Behaviour:
- Reset (rst=0, async): all data=0, tag=0, busy=0, busy_cnt=0. Read outputs follow, so they are 0 while indices are valid.
- Register 0: reads always return data 0, busy 0, tag 0. Renames and commits to register 0 are ignored.
- Updates take effect on a clk edge only when rdy=1. With rdy=0, state holds and read outputs remain live.
- Rename (ren_valid, ren_rd!=0): busy[ren_rd]<=1, tag[ren_rd]<=ren_tag.
- Commit port k (cm_valid[k], cm_rd!=0):
  - data[cm_rd]<=cm_data.
  - busy[cm_rd]<=0 only if tag[cm_rd]==cm_tag (pre-edge value) and no same-cycle rename to cm_rd.
  - A tag mismatch updates data only; busy and tag are unchanged.
- Same cycle rename and commit to the same rd: the rename wins busy/tag, the commit still writes data.
- NCM=2, both ports commit the same rd: port 1's data wins. Busy clears if either port's tag matches, subject to the rename rule above.
- Flush (flush=1 and rdy=1):
  - All busy<=0.
  - Commits in the same cycle still write data.
  - A rename in the same cycle is dropped.
  - Tags are retained, don't-care.
- Reads are combinational from state, plus the bypass described under Optional Feature.
- busy_cnt:
  - Registered; equals the popcount of busy after each edge.
  - Updated incrementally: +1 for a rename of a not-busy rd, -1 per cleared register; 0 after a flush.
  - Never exceeds NREGS-1.
- Latency: a rename is visible on reads the cycle after its edge. Commit visibility depends on the Optional Feature.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: a read port whose index equals a valid commit's cm_rd (nonzero) returns that cm_data in the same cycle.
  - Port 1 has priority over port 0.
  - rd_busy=0 if the matching commit's cm_tag equals tag[idx] and there is no same-cycle rename of idx.
  - Otherwise rd_busy keeps the registered state.
- Undefined: reads reflect registered state only; commit data and busy release become visible one cycle after the edge.

Test Plan:
- Async reset mid-traffic: rename x5 tag 3, deassert clk and pulse rst low -> rd_busy=0, rd_data=0, busy_cnt=0 immediately, without waiting for a clock edge.
- Rename x5 tag 3, then commit x5 tag 3 data 0xDEADBEEF -> next cycle rd_data=0xDEADBEEF, rd_busy=0, busy_cnt 1->0. With RF_COMMIT_BYPASS_EN, the read in the commit cycle already shows 0xDEADBEEF, busy 0.
- Stale commit: rename x7 tag 2, rename x7 tag 9, commit x7 tag 2 data 0x11 -> data=0x11, rd_busy=1, rd_tag=9, busy_cnt=1.
- Same-cycle rename x4 tag 6 and commit x4 tag (old) 1 data 0x22 -> busy=1, tag=6, data=0x22.
- Flush with x1/x2/x3 busy plus a concurrent commit x2 data 0x33 and rename x8 -> all busy 0, x2=0x33, x8 not busy, busy_cnt=0.
- NCM=2, NRD=3: commit x10 on both ports (data 0xA, 0xB) with rdy=0 -> no change. Then rdy=1 -> x10=0xB. Renames/commits to x0 -> x0 reads 0, not busy.
